// File: rtl/cdc_rx_buffer.sv
// cdc_rx_buffer: receive-side elastic FWFT FIFO in the B clock domain, fed by single-cycle CDC valid pulses.
// Latency: a word written into an empty FIFO is presented on o_valid/o_data on the next cycle.
// Backpressure: i_valid cannot be stalled; words arriving while full (and no same-cycle pop) are dropped and flagged.
//
// Ports:
//   i_clk, i_rst_n         clock and asynchronous active-low reset
//   i_valid, i_data        write strobe / data from the CDC (no ready; never stalled)
//   o_valid, o_data        head-of-FIFO stream, popped on o_valid && i_ready
//   i_ready                consumer accept
//   o_count                occupancy 0..G_DEPTH
//   o_almost_full          o_count >= G_AFULL (registered)
//   o_overflow             sticky dropped-word flag, cleared by i_clr_overflow (set wins)
//   o_drop_cnt             saturating 8-bit dropped-word count, present only when
//                          CDC_RX_BUFFER_DROP_CNT_EN is defined; i_clr_overflow also clears it
module cdc_rx_buffer #(
  parameter int G_WIDTH = 4,
  parameter int G_DEPTH = 8,
  parameter int G_AFULL = 6
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  input  logic [G_WIDTH-1:0]           i_data,
  output logic                         o_valid,
  output logic [G_WIDTH-1:0]           o_data,
  input  logic                         i_ready,
  output logic [$clog2(G_DEPTH+1)-1:0] o_count,
  output logic                         o_almost_full,
  output logic                         o_overflow,
  input  logic                         i_clr_overflow
`ifdef CDC_RX_BUFFER_DROP_CNT_EN
  ,
  output logic [7:0]                   o_drop_cnt
`endif
);

  localparam int AW = $clog2(G_DEPTH);
  localparam int CW = $clog2(G_DEPTH+1);

  logic [G_WIDTH-1:0] mem [G_DEPTH];
  // One extra MSB on each pointer distinguishes full from empty when the indices match.
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               empty;
  logic               full;
  logic               wr;
  logic               rd;
  logic               drop;
  logic [CW-1:0]      count_nxt;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Head entry comes straight out of the storage registers, so i_valid/i_data
  // only reach the outputs through a clock edge.
  assign o_valid = !empty;
  assign o_data  = mem[rd_ptr[AW-1:0]];

  assign rd   = o_valid && i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr   = i_valid && (!full || rd);
  assign drop = i_valid && full && !rd;

  always_comb begin
    count_nxt = o_count;
    if (wr && !rd) begin
      count_nxt = o_count + CW'(1);
    end else if (rd && !wr) begin
      count_nxt = o_count - CW'(1);
    end
  end

  // Storage is reset too, so o_data reads 0 out of reset and no stale word survives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < G_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr) begin
      mem[wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_count       <= '0;
      o_almost_full <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      o_count       <= count_nxt;
      // Computed from the next count so the flag lines up with o_count.
      o_almost_full <= (count_nxt >= CW'(G_AFULL));
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
    end else if (drop) begin
      o_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      o_overflow <= 1'b0;
    end
  end

`ifdef CDC_RX_BUFFER_DROP_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop_cnt <= '0;
    end else if (i_clr_overflow) begin
      o_drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop && (o_drop_cnt != 8'hFF)) begin
      o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end
`endif

endmodule
